// File: rtl/demux_1xn_stream.sv
// rtl/demux_1xn_stream.sv - registered 1:N valid/ready stream demultiplexer; optional broadcast via DEMUX_BCAST_EN
module demux_1xn_stream #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
`ifdef DEMUX_BCAST_EN
    input  logic                 in_bcast,
`endif
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic                 sel_err
);

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    // N widened by one bit so the range test also works when N is a power of two
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    ch_state_e        state_q [N];
    ch_state_e        state_d [N];
    logic [WIDTH-1:0] data_q  [N];
    logic [WIDTH-1:0] data_d  [N];
    logic             sel_err_q;
    logic             sel_err_d;

    logic             bcast;
    logic             sel_in_range;
    logic [N-1:0]     sel_oh;
    logic [N-1:0]     can_acc;
    logic [N-1:0]     load;
    logic             xfer;

`ifdef DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // Decode the destination and work out which channels could take a word this cycle
    always_comb begin
        sel_in_range = ({1'b0, in_sel} < N_EXT);
        sel_oh       = '0;
        can_acc      = '0;
        for (int c = 0; c < N; c++) begin
            // A full channel frees its slot in the same cycle its consumer takes the word
            can_acc[c] = (state_q[c] == CH_EMPTY) | out_ready[c];
            sel_oh[c]  = ({1'b0, in_sel} == (SEL_W+1)'(c));
        end
    end

    // Input handshake: out-of-range words are always accepted and dropped; broadcast is all-or-nothing
    always_comb begin
        in_ready = 1'b1;
        if (bcast) begin
            in_ready = &can_acc;
        end else if (sel_in_range) begin
            in_ready = |(sel_oh & can_acc);
        end
        xfer      = in_valid & in_ready;
        load      = {N{xfer}} & (bcast ? {N{1'b1}} : sel_oh);
        sel_err_d = xfer & ~bcast & ~sel_in_range;
    end

    // Per-channel EMPTY/FULL next state and data capture
    always_comb begin
        for (int c = 0; c < N; c++) begin
            state_d[c] = state_q[c];
            data_d[c]  = data_q[c];
            case (state_q[c])
                CH_EMPTY: begin
                    if (load[c]) begin
                        state_d[c] = CH_FULL;
                    end
                end
                CH_FULL: begin
                    // Drained and not refilled: go empty; drained and refilled: stay full
                    if (out_ready[c] && !load[c]) begin
                        state_d[c] = CH_EMPTY;
                    end
                end
                default: begin
                    state_d[c] = CH_EMPTY;
                end
            endcase
            if (load[c]) begin
                data_d[c] = in_data;
            end
        end
    end

    // State, data and error-pulse registers; reset empties every channel at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                state_q[c] <= CH_EMPTY;
                data_q[c]  <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            for (int c = 0; c < N; c++) begin
                state_q[c] <= state_d[c];
                data_q[c]  <= data_d[c];
            end
            sel_err_q <= sel_err_d;
        end
    end

    for (genvar c = 0; c < N; c++) begin : gen_out
        assign out_data[c*WIDTH +: WIDTH] = data_q[c];
        assign out_valid[c]               = (state_q[c] == CH_FULL);
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// tb/tb_demux_1xn_stream.sv - scoreboard bench for demux_1xn_stream, N=4 and N=3 instances
`timescale 1ns/1ps
module tb_demux_1xn_stream;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int NN = (g == 0) ? 4 : 3;
        localparam int SW = $clog2(NN);

        logic                rst_n;
        logic [WIDTH-1:0]    in_data;
        logic [SW-1:0]       in_sel;
        logic                in_valid;
        logic                in_ready;
        logic [NN*WIDTH-1:0] out_data;
        logic [NN-1:0]       out_valid;
        logic [NN-1:0]       out_ready;
        logic                sel_err;
`ifdef DEMUX_BCAST_EN
        logic                in_bcast;
`endif

        demux_1xn_stream #(.N(NN), .WIDTH(WIDTH)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (in_data),
            .in_sel    (in_sel),
            .in_valid  (in_valid),
`ifdef DEMUX_BCAST_EN
            .in_bcast  (in_bcast),
`endif
            .in_ready  (in_ready),
            .out_data  (out_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sel_err   (sel_err)
        );

        // Reference model: each channel is a queue of words loaded but not yet consumed
        logic [WIDTH-1:0] exp_q [NN][$];
        bit               pend [NN];
        bit               err_pend;
        bit               err_next;
        bit               done;

        function automatic bit model_ready(input int sel, input bit bc, input logic [NN-1:0] ordy);
            if (bc) begin
                for (int c = 0; c < NN; c++) begin
                    if (exp_q[c].size() != 0 && !ordy[c]) return 1'b0;
                end
                return 1'b1;
            end
            if (sel >= NN) return 1'b1;
            return (exp_q[sel].size() == 0) || ordy[sel];
        endfunction

        task automatic step(input bit v, input int sel, input logic [WIDTH-1:0] d,
                            input logic [NN-1:0] ordy, input bit bc);
            bit rdy;
            @(negedge clk);
            #1;
            in_valid  = v;
            in_sel    = SW'(sel);
            in_data   = d;
            out_ready = ordy;
`ifdef DEMUX_BCAST_EN
            in_bcast  = bc;
`endif
            #1;
            rdy = model_ready(sel, bc, ordy);
            chk($sformatf("in_ready_n%0d", NN), {31'b0, in_ready}, {31'b0, rdy});
            if (v && rdy) begin
                if (bc) begin
                    for (int c = 0; c < NN; c++) begin
                        exp_q[c].push_back(d);
                        pend[c] = 1'b1;
                    end
                end else if (sel < NN) begin
                    exp_q[sel].push_back(d);
                    pend[sel] = 1'b1;
                end else begin
                    err_pend = 1'b1;
                end
            end
        endtask

        task automatic reset_checks(input string tag);
            chk($sformatf("%s_out_valid_n%0d", tag, NN), 32'(out_valid), 32'd0);
            chk($sformatf("%s_out_data_n%0d", tag, NN), 32'(out_data), 32'd0);
            chk($sformatf("%s_sel_err_n%0d", tag, NN), {31'b0, sel_err}, 32'd0);
        endtask

        task automatic clear_model();
            for (int c = 0; c < NN; c++) begin
                exp_q[c].delete();
                pend[c] = 1'b0;
            end
            err_pend = 1'b0;
            err_next = 1'b0;
        endtask

        // Monitor: just before each rising edge, compare DUT outputs with the model
        initial begin : monitor
            bit               ev;
            logic [WIDTH-1:0] w;
            while (!done) begin
                @(negedge clk);
                #4;
                if (rst_n === 1'b1) begin
                    for (int c = 0; c < NN; c++) begin
                        ev = exp_q[c].size() > (pend[c] ? 1 : 0);
                        chk($sformatf("out_valid_n%0d_ch%0d", NN, c), {31'b0, out_valid[c]}, {31'b0, ev});
                        if (ev && out_ready[c]) begin
                            w = exp_q[c].pop_front();
                            chk($sformatf("out_data_n%0d_ch%0d", NN, c),
                                32'(out_data[c*WIDTH +: WIDTH]), 32'(w));
                        end
                        pend[c] = 1'b0;
                    end
                    chk($sformatf("sel_err_n%0d", NN), {31'b0, sel_err}, {31'b0, err_next});
                    err_next = err_pend;
                    err_pend = 1'b0;
                end
            end
        end

        // Driver: directed scenarios, then randomized traffic
        initial begin : driver
            logic [NN-1:0] m;
            done      = 1'b0;
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            in_sel    = '0;
            in_data   = '0;
            out_ready = '0;
`ifdef DEMUX_BCAST_EN
            in_bcast  = 1'b0;
`endif
            #3;
            reset_checks("por");
            repeat (2) @(negedge clk);
            #1;
            rst_n = 1'b1;

            // Routing, back-to-back, everything ready
            for (int c = 0; c < NN; c++) step(1'b1, c, 8'hA0 + 8'(c), '1, 1'b0);
            repeat (2) step(1'b0, 0, 8'h00, '1, 1'b0);

            // Back-pressure on channel 1, independence of the last channel
            m    = '1;
            m[1] = 1'b0;
            step(1'b1, 1, 8'h11, m, 1'b0);
            step(1'b1, 1, 8'h22, m, 1'b0);
            step(1'b1, 1, 8'h22, m, 1'b0);
            step(1'b1, NN - 1, 8'h55, m, 1'b0);
            step(1'b0, 0, 8'h00, m, 1'b0);
            step(1'b1, 1, 8'h22, '1, 1'b0);
            repeat (2) step(1'b0, 0, 8'h00, '1, 1'b0);

            // Highest encodable select: out of range on the N=3 instance
            step(1'b1, (1 << SW) - 1, 8'hFF, '1, 1'b0);
            repeat (3) step(1'b0, 0, 8'h00, '1, 1'b0);

`ifdef DEMUX_BCAST_EN
            // Broadcast blocked by a stalled channel 0, then released
            m    = '1;
            m[0] = 1'b0;
            step(1'b1, 0, 8'h01, m, 1'b0);
            step(1'b1, 0, 8'h5A, m, 1'b1);
            step(1'b1, 0, 8'h5A, '1, 1'b1);
            repeat (2) step(1'b0, 0, 8'h00, '1, 1'b0);
`endif

            // Reset mid-operation with channel 2 full and stalled
            step(1'b1, 2, 8'h77, '0, 1'b0);
            @(negedge clk);
            #2;
            in_valid = 1'b0;
            rst_n    = 1'b0;
            #1;
            reset_checks("midrst");
            clear_model();
            @(negedge clk);
            #1;
            rst_n = 1'b1;

            // Randomized traffic, including out-of-range selects on the N=3 instance
            repeat (400) begin
                bit bc;
                bc = 1'b0;
`ifdef DEMUX_BCAST_EN
                bc = ($urandom % 8) == 0;
`endif
                step(($urandom % 4) != 0, int'($urandom_range(0, (1 << SW) - 1)),
                     WIDTH'($urandom), NN'($urandom), bc);
            end
            repeat (4) step(1'b0, 0, 8'h00, '1, 1'b0);
            done = 1'b1;
        end
    end

    // Wait for both instances, bounded, then report
    initial begin : supervisor
        int cyc;
        cyc = 0;
        while (!(gen_inst[0].done && gen_inst[1].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL timeout cycles=%0d required<20000", cyc);
        end
        @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
